// File: rtl/ann_pkg.sv
// -----------------------------------------------------------------------------
// ann_pkg
// Constants shared by the MLP datapath blocks.
//   MODE_*  : 2-bit operation codes for data_shift_bank
// -----------------------------------------------------------------------------
package ann_pkg;

   localparam logic [1:0] MODE_HOLD   = 2'b00;
   localparam logic [1:0] MODE_SHIFT  = 2'b01;
   localparam logic [1:0] MODE_ROTATE = 2'b10;
   localparam logic [1:0] MODE_LOAD   = 2'b11;

endpackage : ann_pkg

// File: rtl/data_shift_bank_if.sv
// -----------------------------------------------------------------------------
// data_shift_bank_if
// Control and data bundle of data_shift_bank.
//   master : drives clr, en, mode, din, pin; observes the bank outputs
//   slave  : the bank itself; drives dout, pout, count, full, wrap, ovf
// Entry i of pin/pout occupies bits [i*WIDTH +: WIDTH].
// -----------------------------------------------------------------------------
interface data_shift_bank_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                     clr;
   logic                     en;
   logic [1:0]               mode;
   logic [WIDTH-1:0]         din;
   logic [WIDTH*DEPTH-1:0]   pin;
   logic [WIDTH-1:0]         dout;
   logic [WIDTH*DEPTH-1:0]   pout;
   logic [CNT_W-1:0]         count;
   logic                     full;
   logic                     wrap;
   logic                     ovf;

   modport master (
      output clr, en, mode, din, pin,
      input  dout, pout, count, full, wrap, ovf
   );

   modport slave (
      input  clr, en, mode, din, pin,
      output dout, pout, count, full, wrap, ovf
   );

endinterface : data_shift_bank_if

// File: rtl/reg_en_w.sv
// -----------------------------------------------------------------------------
// reg_en_w
// WIDTH-bit register with synchronous active-high reset and load enable.
//   clk : rising-edge clock
//   rst : synchronous reset, clears the register to 0
//   en  : load d on the next edge; otherwise hold
//   d   : next value
//   q   : registered value
// -----------------------------------------------------------------------------
module reg_en_w #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      data_d = en ? d : data_q;
   end

   // NOTE: every data register is reset, not just the control state; rotating
   // a partially filled bank moves the unused entries onto dout, so they must
   // start at a known 0.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so all flops sample pre-edge values.
      if (rst) data_q <= '0;
      else     data_q <= data_d;
   end

   assign q = data_q;

endmodule : reg_en_w

// File: rtl/data_shift_bank.sv
// -----------------------------------------------------------------------------
// data_shift_bank
// DEPTH x WIDTH register bank feeding the neuron MAC. Operands arrive serially
// (SHIFT) or in one cycle (LOAD) and are then circulated (ROTATE) so the MAC
// sees one value per cycle on dout; wrap pulses after each complete pass.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : data_shift_bank_if.slave
//          clr   synchronous functional clear (entries, count, pass position)
//          en    operation enable, 0 = hold
//          mode  HOLD / SHIFT / ROTATE / LOAD (ann_pkg::MODE_*)
//          din   serial input for SHIFT
//          pin   parallel input for LOAD
//          dout  entry DEPTH-1 (head)
//          pout  all entries
//          count number of valid entries, full = (count == DEPTH)
//          wrap  one-cycle pulse after the DEPTH-th consecutive rotate
//          ovf   one-cycle pulse after a SHIFT into a full bank
// -----------------------------------------------------------------------------
module data_shift_bank
   import ann_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   data_shift_bank_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

   // ---------------------------------------------------------------------------
   // Entry storage
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] entry_q [DEPTH];
   logic [WIDTH-1:0] entry_d [DEPTH];
   logic [DEPTH-1:0] entry_en;
   logic [WIDTH-1:0] feed    [DEPTH];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      reg_en_w #(.WIDTH(WIDTH)) u_entry (
         .clk (clk),
         .rst (rst),
         .en  (entry_en[gi]),
         .d   (entry_d[gi]),
         .q   (entry_q[gi])
      );
      assign bus.pout[gi*WIDTH +: WIDTH] = entry_q[gi];
   end

   // Value moving into each entry on SHIFT/ROTATE. Both modes move the chain
   // the same way; they differ only in what enters entry 0: din for a shift,
   // the outgoing head for a rotate.
   always_comb begin
      feed[0] = (bus.mode == MODE_ROTATE) ? entry_q[DEPTH-1] : bus.din;
      for (int i = 1; i < DEPTH; i++) begin
         feed[i] = entry_q[i-1];
      end
   end

   // Per-entry next-value mux. clr is realised as a load of zero.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         // NOTE: defaults first so no path through this block leaves an output
         // unassigned, which would otherwise infer a latch.
         entry_en[i] = 1'b0;
         entry_d[i]  = '0;
         if (bus.clr) begin
            entry_en[i] = 1'b1;
         end else if (bus.en) begin
            case (bus.mode)
               MODE_SHIFT, MODE_ROTATE: begin
                  entry_en[i] = 1'b1;
                  entry_d[i]  = feed[i];
               end
               MODE_LOAD: begin
                  entry_en[i] = 1'b1;
                  entry_d[i]  = bus.pin[i*WIDTH +: WIDTH];
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Fill level, pass position and event pulses
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] count_d,   count_q;
   logic [IDX_W-1:0] rot_idx_d, rot_idx_q;
   logic             wrap_d,    wrap_q;
   logic             ovf_d,     ovf_q;

   always_comb begin
      count_d   = count_q;
      rot_idx_d = rot_idx_q;
      wrap_d    = 1'b0;
      ovf_d     = 1'b0;
      if (bus.clr) begin
         count_d   = '0;
         rot_idx_d = '0;
      end else if (bus.en) begin
         case (bus.mode)
            MODE_SHIFT: begin
               // A full bank keeps its count; the head value falls off the end.
               if (count_q == CNT_FULL) ovf_d   = 1'b1;
               else                     count_d = count_q + CNT_W'(1);
               rot_idx_d = '0;
            end
            MODE_ROTATE: begin
               if (rot_idx_q == IDX_LAST) begin
                  rot_idx_d = '0;
                  wrap_d    = 1'b1;
               end else begin
                  rot_idx_d = rot_idx_q + IDX_W'(1);
               end
            end
            MODE_LOAD: begin
               count_d   = CNT_FULL;
               rot_idx_d = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         rot_idx_q <= '0;
         wrap_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         rot_idx_q <= rot_idx_d;
         wrap_q    <= wrap_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.dout  = entry_q[DEPTH-1];
   assign bus.count = count_q;
   assign bus.full  = (count_q == CNT_FULL);
   assign bus.wrap  = wrap_q;
   assign bus.ovf   = ovf_q;

endmodule : data_shift_bank

// File: tb/tb_data_shift_bank.sv
// -----------------------------------------------------------------------------
// tb_data_shift_bank
// Self-checking bench for data_shift_bank (WIDTH=8, DEPTH=4). Each step drives
// one cycle of inputs, advances a behavioural model of the bank and pushes the
// expected post-edge outputs to a scoreboard queue; after the edge the entry is
// popped and compared against the DUT.
// -----------------------------------------------------------------------------
module tb_data_shift_bank;
   import ann_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct {
      logic [WIDTH-1:0]       dout;
      logic [WIDTH*DEPTH-1:0] pout;
      logic [CNT_W-1:0]       count;
      logic                   full;
      logic                   wrap;
      logic                   ovf;
   } exp_t;

   logic clk;
   logic rst;
   data_shift_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   data_shift_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_errors = 0;
   string phase    = "init";

   exp_t  sb[$];
   exp_t  obs;

   // Reference model state
   logic [WIDTH-1:0] m_ent [DEPTH];
   int               m_cnt;
   int               m_rot;
   logic             m_wrap;
   logic             m_ovf;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s.%s: got %0h expected %0h at %0t", phase, tag, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
      m_cnt  = 0;
      m_rot  = 0;
      m_wrap = 1'b0;
      m_ovf  = 1'b0;
   endtask

   task automatic model_step(input logic r, input logic c, input logic e,
                             input logic [1:0] m, input logic [WIDTH-1:0] d,
                             input logic [WIDTH*DEPTH-1:0] p);
      logic [WIDTH-1:0] head;
      m_wrap = 1'b0;
      m_ovf  = 1'b0;
      if (r || c) begin
         model_clear();
      end else if (e) begin
         if (m == MODE_SHIFT) begin
            m_ovf = (m_cnt == DEPTH);
            for (int i = DEPTH - 1; i > 0; i--) m_ent[i] = m_ent[i-1];
            m_ent[0] = d;
            if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
            m_rot = 0;
         end else if (m == MODE_ROTATE) begin
            head = m_ent[DEPTH-1];
            for (int i = DEPTH - 1; i > 0; i--) m_ent[i] = m_ent[i-1];
            m_ent[0] = head;
            m_wrap = (m_rot == DEPTH - 1);
            m_rot  = (m_rot + 1) % DEPTH;
         end else if (m == MODE_LOAD) begin
            for (int i = 0; i < DEPTH; i++) m_ent[i] = p[i*WIDTH +: WIDTH];
            m_cnt = DEPTH;
            m_rot = 0;
         end
      end
   endtask

   function automatic exp_t model_snapshot();
      exp_t x;
      for (int i = 0; i < DEPTH; i++) x.pout[i*WIDTH +: WIDTH] = m_ent[i];
      x.dout  = m_ent[DEPTH-1];
      x.count = CNT_W'(m_cnt);
      x.full  = (m_cnt == DEPTH);
      x.wrap  = m_wrap;
      x.ovf   = m_ovf;
      return x;
   endfunction

   // One clock cycle: drive at negedge, predict, sample #1 after posedge.
   task automatic step(input logic r, input logic c, input logic e,
                       input logic [1:0] m, input logic [WIDTH-1:0] d,
                       input logic [WIDTH*DEPTH-1:0] p);
      exp_t x;
      @(negedge clk);
      rst      = r;
      bus.clr  = c;
      bus.en   = e;
      bus.mode = m;
      bus.din  = d;
      bus.pin  = p;
      model_step(r, c, e, m, d, p);
      sb.push_back(model_snapshot());
      @(posedge clk);
      #1;
      obs.dout  = bus.dout;
      obs.pout  = bus.pout;
      obs.count = bus.count;
      obs.full  = bus.full;
      obs.wrap  = bus.wrap;
      obs.ovf   = bus.ovf;
      if (sb.size() == 0) begin
         check("sb_empty", 64'(sb.size()), 64'd1);
      end else begin
         x = sb.pop_front();
         check("dout",  64'(obs.dout),  64'(x.dout));
         check("pout",  64'(obs.pout),  64'(x.pout));
         check("count", 64'(obs.count), 64'(x.count));
         check("full",  64'(obs.full),  64'(x.full));
         check("wrap",  64'(obs.wrap),  64'(x.wrap));
         check("ovf",   64'(obs.ovf),   64'(x.ovf));
      end
   endtask

   task automatic op(input logic [1:0] m, input logic [WIDTH-1:0] d = '0,
                     input logic [WIDTH*DEPTH-1:0] p = '0);
      step(1'b0, 1'b0, 1'b1, m, d, p);
   endtask

   logic [WIDTH-1:0] shift_vals [4];
   logic [WIDTH-1:0] rot_dout   [4];
   int               wrap_seen;

   initial begin
      rst      = 1'b1;
      bus.clr  = 1'b0;
      bus.en   = 1'b0;
      bus.mode = MODE_HOLD;
      bus.din  = '0;
      bus.pin  = '0;
      model_clear();

      // Reset
      phase = "reset";
      step(1'b1, 1'b0, 1'b0, MODE_HOLD, '0, '0);
      step(1'b1, 1'b0, 1'b0, MODE_HOLD, '0, '0);
      step(1'b0, 1'b0, 1'b0, MODE_HOLD, '0, '0);
      check("pout_zero", 64'(obs.pout), 64'd0);
      check("count_zero", 64'(obs.count), 64'd0);
      phase = "reset_over_load";
      step(1'b1, 1'b0, 1'b1, MODE_LOAD, '0, 32'hFFFF_FFFF);
      check("pout_zero", 64'(obs.pout), 64'd0);
      check("dout_zero", 64'(obs.dout), 64'd0);

      // Serial fill and overflow
      phase = "shift";
      shift_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) op(MODE_SHIFT, shift_vals[i]);
      check("pout_fill", 64'(obs.pout), 64'h1122_3344);
      check("count_fill", 64'(obs.count), 64'd4);
      check("full_fill", 64'(obs.full), 64'd1);
      check("dout_fill", 64'(obs.dout), 64'h11);
      phase = "shift_ovf";
      op(MODE_SHIFT, 8'h55);
      check("ovf_pulse", 64'(obs.ovf), 64'd1);
      check("dout_ovf", 64'(obs.dout), 64'h22);
      check("count_ovf", 64'(obs.count), 64'd4);
      op(MODE_HOLD);
      check("ovf_drop", 64'(obs.ovf), 64'd0);

      // Load and one full rotate pass; the head walks down the loaded entries.
      phase = "rotate_pass";
      op(MODE_LOAD, '0, 32'hA1B2_C3D4);
      check("dout_load", 64'(obs.dout), 64'hA1);
      rot_dout = '{8'hB2, 8'hC3, 8'hD4, 8'hA1};
      for (int i = 0; i < 4; i++) begin
         op(MODE_ROTATE);
         check("dout_rot", 64'(obs.dout), 64'(rot_dout[i]));
         check("wrap_rot", 64'(obs.wrap), (i == 3) ? 64'd1 : 64'd0);
      end
      check("pout_restored", 64'(obs.pout), 64'hA1B2_C3D4);
      op(MODE_ROTATE);
      check("wrap_single", 64'(obs.wrap), 64'd0);

      // Pause mid-pass with en=0
      phase = "rotate_pause";
      op(MODE_LOAD, '0, 32'h0102_0304);
      op(MODE_ROTATE);
      op(MODE_ROTATE);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, MODE_ROTATE, '0, '0);
      op(MODE_ROTATE);
      check("wrap_early", 64'(obs.wrap), 64'd0);
      op(MODE_ROTATE);
      check("wrap_after_pause", 64'(obs.wrap), 64'd1);

      // clr mid-pass restarts the pass
      phase = "clr_mid_pass";
      op(MODE_LOAD, '0, 32'hDEAD_BEEF);
      op(MODE_ROTATE);
      op(MODE_ROTATE);
      step(1'b0, 1'b1, 1'b0, MODE_HOLD, '0, '0);
      check("pout_clr", 64'(obs.pout), 64'd0);
      check("count_clr", 64'(obs.count), 64'd0);
      wrap_seen = 0;
      for (int i = 0; i < 4; i++) begin
         op(MODE_ROTATE);
         if (obs.wrap) wrap_seen++;
      end
      check("wrap_after_clr", 64'(obs.wrap), 64'd1);
      check("wrap_count_clr", 64'(wrap_seen), 64'd1);

      // rst mid-pass: no wrap from the aborted pass
      phase = "rst_mid_pass";
      op(MODE_LOAD, '0, 32'h1234_5678);
      op(MODE_ROTATE);
      op(MODE_ROTATE);
      wrap_seen = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b1, MODE_ROTATE, '0, '0);
         if (obs.wrap) wrap_seen++;
      end
      for (int i = 0; i < 2; i++) begin
         op(MODE_ROTATE);
         if (obs.wrap) wrap_seen++;
      end
      check("wrap_none_rst", 64'(wrap_seen), 64'd0);

      // Mode change mid-pass zeroes the position
      phase = "mode_change";
      op(MODE_LOAD, '0, 32'hCAFE_F00D);
      op(MODE_ROTATE);
      op(MODE_ROTATE);
      op(MODE_SHIFT, 8'h9A);
      op(MODE_ROTATE);
      op(MODE_ROTATE);
      check("wrap_after_shift", 64'(obs.wrap), 64'd0);

      // clr beats a simultaneous shift
      phase = "clr_vs_shift";
      step(1'b0, 1'b1, 1'b1, MODE_SHIFT, 8'h77, '0);
      check("pout_clr_wins", 64'(obs.pout), 64'd0);
      check("count_clr_wins", 64'(obs.count), 64'd0);

      // Partial fill then rotate: zeros circulate with the valid entries
      phase = "partial_rotate";
      op(MODE_SHIFT, 8'h5A);
      op(MODE_SHIFT, 8'hC3);
      for (int i = 0; i < 4; i++) op(MODE_ROTATE);
      check("pout_partial", 64'(obs.pout), 64'h0000_5AC3);

      // Random traffic against the model
      phase = "random";
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
              8'($urandom), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_data_shift_bank
